video_fetch_sched: RTL and testbench
====================================

Name: video_fetch_sched

Overview:
Per-line scheduler for video DRAM fetches. It consumes the horizontal timing strobes (fetch_start, fetch_end, line_start) and a frame strobe. It drives the 'go' request to the DRAM arbiter, generates the sequential video fetch address and counts delivered words against a mode-dependent quota. It sits between the horizontal/vertical sync generators and the DRAM controller, and flags underruns and spurious deliveries.

Parameters:
WORDS_PENT, 32, 16-bit words fetched per line in Pentagon x256 mode
WORDS_ATM, 80, words per line in ATM x320 graphics mode
WORDS_TEXT, 40, words per line in ATM text mode
AW, 21, video address width (words)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cend  in  1  7 MHz video cycle end strobe
frame_start  in  1  one-clk pulse at start of frame (vertical)
vpix  in  1  vertical pixel window active
line_start  in  1  one-clk pulse, start of line
fetch_start  in  1  one-clk pulse, begin fetch window
fetch_end  in  1  one-clk pulse, end fetch window
mode_atm_n_pent  in  1  1=ATM, 0=Pentagon
mode_a_text  in  1  ATM text mode (valid when mode_atm_n_pent=1)
vbase  in  AW  frame base word address
video_next  in  1  one-clk pulse per word delivered by DRAM controller
err_clr  in  1  clears err
video_go  out  1  fetch request to DRAM arbiter
video_addr  out  AW  address of next word to fetch
line_done  out  1  one-clk pulse when line fetch finishes
word_cnt  out  7  words delivered this line
err  out  2  sticky: [0] underrun, [1] spurious video_next

Behaviour:
- Reset (async, rst_n=0): state=IDLE, video_go=0, video_addr=0, word_cnt=0, line_done=0, err=0, quota=0.
- All control is per clk; cend is not used for gating. Inputs are already cend-aligned pulses.
- States: IDLE, ARMED, FETCH, DONE.
- frame_start in any state, highest priority: state->ARMED, video_addr<=vbase, word_cnt<=0, video_go<=0 next cycle. An in-progress line is aborted with no underrun flag.
- IDLE: waits for frame_start.
- ARMED:
  - fetch_start & vpix -> FETCH; word_cnt<=0.
  - Latch quota: WORDS_TEXT if atm&text, WORDS_ATM if atm, else WORDS_PENT.
  - fetch_start & !vpix -> stay ARMED.
- FETCH:
  - video_go=1, registered: rises the clk after fetch_start.
  - Each video_next: video_addr+1 (wraps mod 2^AW), word_cnt+1.
  - Exit to DONE when the updated word_cnt==quota, or when fetch_end arrives, whichever is first.
  - video_go=0 from the following clk; line_done pulses 1 clk on the transition.
  - fetch_end with updated word_cnt<quota sets err[0]. A video_next on the same clk as fetch_end is counted first.
  - Mode inputs changing in FETCH have no effect; quota is latched.
- DONE: line_start -> ARMED. fetch_start received in DONE is ignored.
- video_next outside FETCH:
  - Ignored for address and count.
  - Sets err[1], except the single clk immediately after FETCH->DONE, which is allowed for arbiter pipeline latency and counted normally.
- err bits are sticky until err_clr. When err_clr and a set event occur on the same clk, the set wins.
- video_addr is continuous across lines: no per-line reload except frame_start.
- word_cnt holds its value in DONE/ARMED until the next FETCH entry.

Test Plan:
- Pentagon line: vbase=0x100, frame_start, then fetch_start with vpix=1, then 32 video_next pulses before fetch_end -> video_go high 1 clk after fetch_start; line_done and go low after the 32nd pulse; video_addr=0x120; err=0.
- Underrun, ATM graphics: 50 video_next pulses then fetch_end -> err[0]=1, word_cnt=50, video_addr advanced by 50, line_done pulses at fetch_end.
- Text mode plus mid-line mode change: quota latched at 40; toggling mode_a_text during FETCH -> go ends after exactly 40 words.
- Spurious/late delivery: video_next 1 clk after completion -> counted, no error; video_next 3 clks later -> err[1]=1; err_clr clears it.
- Mid-line abort: frame_start during FETCH with vbase=0x2000 -> go drops next clk, video_addr=0x2000, no underrun, state ARMED; fetch_start with vpix=0 -> go stays 0.
- Async reset asserted mid-FETCH -> all outputs 0 immediately without a clk edge; wrap check: vbase=2^21-2, 4 words -> video_addr=2.

Source files
------------

// File: rtl/video_fetch_sched_if.sv
// Signal bundle between the sync generators, the DRAM controller and the
// per-line video fetch scheduler.
interface video_fetch_sched_if #(
    parameter int AW = 21
) ();
    logic          cend;
    logic          frame_start;
    logic          vpix;
    logic          line_start;
    logic          fetch_start;
    logic          fetch_end;
    logic          mode_atm_n_pent;
    logic          mode_a_text;
    logic [AW-1:0] vbase;
    logic          video_next;
    logic          err_clr;
    logic          video_go;
    logic [AW-1:0] video_addr;
    logic          line_done;
    logic [6:0]    word_cnt;
    logic [1:0]    err;

    modport slave (
        input  cend, frame_start, vpix, line_start, fetch_start, fetch_end,
        input  mode_atm_n_pent, mode_a_text, vbase, video_next, err_clr,
        output video_go, video_addr, line_done, word_cnt, err
    );

    modport master (
        output cend, frame_start, vpix, line_start, fetch_start, fetch_end,
        output mode_atm_n_pent, mode_a_text, vbase, video_next, err_clr,
        input  video_go, video_addr, line_done, word_cnt, err
    );
endinterface

// File: rtl/video_fetch_sched.sv
// Per-line video DRAM fetch scheduler: raises go for one fetch window per line,
// walks the frame address and counts delivered words against a latched quota.
module video_fetch_sched #(
    parameter int WORDS_PENT = 32,
    parameter int WORDS_ATM  = 80,
    parameter int WORDS_TEXT = 40,
    parameter int AW         = 21
) (
    input  logic                 clk,
    input  logic                 rst_n,
    video_fetch_sched_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ARMED, FETCH, DONE} state_t;

    localparam logic [6:0] QUOTA_PENT = 7'(WORDS_PENT);
    localparam logic [6:0] QUOTA_ATM  = 7'(WORDS_ATM);
    localparam logic [6:0] QUOTA_TEXT = 7'(WORDS_TEXT);

    state_t        state_q, state_d;
    logic          go_q, go_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [6:0]    quota_q, quota_d;
    logic          done_q, done_d;
    logic          late_q, late_d;
    logic [1:0]    err_q, err_d;
    logic [1:0]    err_set;
    logic [6:0]    cnt_upd;

    // Inputs arrive already aligned to the video cycle, so cend carries no extra information.
    logic unused_cend;
    assign unused_cend = bus.cend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            quota_q <= '0;
            done_q  <= 1'b0;
            late_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            quota_q <= quota_d;
            done_q  <= done_d;
            late_q  <= late_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        go_d    = go_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        quota_d = quota_q;
        done_d  = 1'b0;
        late_d  = 1'b0;
        err_set = 2'b00;
        cnt_upd = cnt_q + 7'(bus.video_next);

        // One trailing word right after a line completes is arbiter latency, not an error.
        if (bus.video_next && (state_q != FETCH)) begin
            if (late_q) begin
                addr_d = addr_q + AW'(1);
                cnt_d  = cnt_q + 7'd1;
            end else begin
                err_set[1] = 1'b1;
            end
        end

        if (bus.frame_start) begin
            state_d = ARMED;
            go_d    = 1'b0;
            addr_d  = bus.vbase;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ARMED: begin
                    if (bus.fetch_start && bus.vpix) begin
                        state_d = FETCH;
                        go_d    = 1'b1;
                        cnt_d   = '0;
                        if (bus.mode_atm_n_pent && bus.mode_a_text)
                            quota_d = QUOTA_TEXT;
                        else if (bus.mode_atm_n_pent)
                            quota_d = QUOTA_ATM;
                        else
                            quota_d = QUOTA_PENT;
                    end
                end
                FETCH: begin
                    if (bus.video_next) begin
                        addr_d = addr_q + AW'(1);
                        cnt_d  = cnt_upd;
                    end
                    if ((cnt_upd == quota_q) || bus.fetch_end) begin
                        state_d = DONE;
                        go_d    = 1'b0;
                        done_d  = 1'b1;
                        late_d  = 1'b1;
                        if (bus.fetch_end && (cnt_upd < quota_q))
                            err_set[0] = 1'b1;
                    end
                end
                DONE: begin
                    if (bus.line_start)
                        state_d = ARMED;
                end
                default: state_d = IDLE;
            endcase
        end

        // A set event on the same clock as a clear must survive.
        err_d = (err_q & ~{2{bus.err_clr}}) | err_set;
    end

    assign bus.video_go   = go_q;
    assign bus.video_addr = addr_q;
    assign bus.line_done  = done_q;
    assign bus.word_cnt   = cnt_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_video_fetch_sched.sv
// Directed bench for video_fetch_sched: a vector table for the first line, then
// hand-written sequences for quota, underrun, late/spurious words, abort, reset and wrap.
module tb_video_fetch_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    video_fetch_sched_if #(.AW(21)) bus ();

    video_fetch_sched #(
        .WORDS_PENT(32), .WORDS_ATM(80), .WORDS_TEXT(40), .AW(21)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        string       nm;
        logic        fs, vp, ls, fst, fen, vn, ec;
        logic        eg;
        logic [20:0] ea;
        logic [6:0]  ecnt;
        logic        eld;
        logic [1:0]  eerr;
    } vec_t;

    vec_t vt[7];

    function automatic vec_t mk(input string nm,
                                input logic fs, input logic vp, input logic ls,
                                input logic fst, input logic fen, input logic vn,
                                input logic ec, input logic eg, input logic [20:0] ea,
                                input logic [6:0] ecnt, input logic eld,
                                input logic [1:0] eerr);
        vec_t v;
        v.nm = nm; v.fs = fs; v.vp = vp; v.ls = ls; v.fst = fst; v.fen = fen;
        v.vn = vn; v.ec = ec; v.eg = eg; v.ea = ea; v.ecnt = ecnt; v.eld = eld;
        v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic eg, input logic [20:0] ea,
                           input logic [6:0] ecnt, input logic eld, input logic [1:0] eerr);
        chk({nm, ".go"},   32'(bus.video_go),   32'(eg));
        chk({nm, ".addr"}, 32'(bus.video_addr), 32'(ea));
        chk({nm, ".cnt"},  32'(bus.word_cnt),   32'(ecnt));
        chk({nm, ".done"}, 32'(bus.line_done),  32'(eld));
        chk({nm, ".err"},  32'(bus.err),        32'(eerr));
        $display("txn %-14s go=%0d addr=%06h cnt=%0d done=%0d err=%b", nm,
                 bus.video_go, bus.video_addr, bus.word_cnt, bus.line_done, bus.err);
    endtask

    // Drive one clock of inputs at the falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input logic fs, input logic vp, input logic ls, input logic fst,
                       input logic fen, input logic vn, input logic ec);
        @(negedge clk);
        bus.frame_start = fs; bus.vpix = vp; bus.line_start = ls;
        bus.fetch_start = fst; bus.fetch_end = fen; bus.video_next = vn;
        bus.err_clr = ec;
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0; bus.line_start = 1'b0; bus.fetch_start = 1'b0;
        bus.fetch_end = 1'b0; bus.video_next = 1'b0; bus.err_clr = 1'b0;
    endtask

    initial begin
        bus.cend = 1'b0; bus.frame_start = 1'b0; bus.vpix = 1'b0;
        bus.line_start = 1'b0; bus.fetch_start = 1'b0; bus.fetch_end = 1'b0;
        bus.mode_atm_n_pent = 1'b0; bus.mode_a_text = 1'b0; bus.vbase = 21'h100;
        bus.video_next = 1'b0; bus.err_clr = 1'b0;

        vt[0] = mk("idle_ignore", 0,1,0,1,0,0,0, 0, 21'h000, 7'd0, 0, 2'b00);
        vt[1] = mk("frame_start", 1,0,0,0,0,0,0, 0, 21'h100, 7'd0, 0, 2'b00);
        vt[2] = mk("fetch_novpix",0,0,0,1,0,0,0, 0, 21'h100, 7'd0, 0, 2'b00);
        vt[3] = mk("fetch_start", 0,1,0,1,0,0,0, 1, 21'h100, 7'd0, 0, 2'b00);
        vt[4] = mk("word1",       0,1,0,0,0,1,0, 1, 21'h101, 7'd1, 0, 2'b00);
        vt[5] = mk("word2",       0,1,0,0,0,1,0, 1, 21'h102, 7'd2, 0, 2'b00);
        vt[6] = mk("gap",         0,1,0,0,0,0,0, 1, 21'h102, 7'd2, 0, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 21'h0, 7'd0, 0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // Pentagon line, vbase 0x100, quota 32
        for (int i = 0; i < 7; i++) begin
            cyc(vt[i].fs, vt[i].vp, vt[i].ls, vt[i].fst, vt[i].fen, vt[i].vn, vt[i].ec);
            chk_all(vt[i].nm, vt[i].eg, vt[i].ea, vt[i].ecnt, vt[i].eld, vt[i].eerr);
        end
        for (int k = 3; k <= 32; k++) begin
            cyc(0,1,0,0,0,1,0);
            chk_all($sformatf("pent_w%0d", k), k < 32, 21'(32'h100 + k), 7'(k), k == 32, 2'b00);
        end

        // Late word in the grace clock, then a spurious one, then clears
        cyc(0,1,0,0,0,1,0); chk_all("late_ok", 0, 21'h121, 7'd33, 0, 2'b00);
        cyc(0,1,0,0,0,0,0); chk_all("idle_a", 0, 21'h121, 7'd33, 0, 2'b00);
        cyc(0,1,0,1,0,0,0); chk_all("done_fst_ign", 0, 21'h121, 7'd33, 0, 2'b00);
        cyc(0,1,0,0,0,1,0); chk_all("spurious", 0, 21'h121, 7'd33, 0, 2'b10);
        cyc(0,1,0,0,0,0,1); chk_all("err_clr", 0, 21'h121, 7'd33, 0, 2'b00);
        cyc(0,1,0,0,0,1,1); chk_all("set_beats_clr", 0, 21'h121, 7'd33, 0, 2'b10);
        cyc(0,1,0,0,0,0,1); chk_all("err_clr2", 0, 21'h121, 7'd33, 0, 2'b00);

        // ATM graphics underrun: 50 of 80 words
        bus.mode_atm_n_pent = 1'b1; bus.mode_a_text = 1'b0;
        cyc(0,1,1,0,0,0,0); chk_all("atm_armed", 0, 21'h121, 7'd33, 0, 2'b00);
        cyc(0,1,0,1,0,0,0); chk_all("atm_go", 1, 21'h121, 7'd0, 0, 2'b00);
        for (int k = 1; k <= 50; k++) begin
            cyc(0,1,0,0,0,1,0);
            chk_all($sformatf("atm_w%0d", k), 1, 21'(32'h121 + k), 7'(k), 0, 2'b00);
        end
        cyc(0,1,0,0,1,0,0); chk_all("atm_underrun", 0, 21'h153, 7'd50, 1, 2'b01);
        cyc(0,1,0,0,0,0,0); chk_all("atm_after", 0, 21'h153, 7'd50, 0, 2'b01);
        cyc(0,1,0,0,0,0,1); chk_all("atm_clr", 0, 21'h153, 7'd50, 0, 2'b00);

        // Text mode, quota latched at 40 while mode_a_text toggles
        bus.mode_a_text = 1'b1;
        cyc(0,1,1,0,0,0,0); chk_all("txt_armed", 0, 21'h153, 7'd50, 0, 2'b00);
        cyc(0,1,0,1,0,0,0); chk_all("txt_go", 1, 21'h153, 7'd0, 0, 2'b00);
        for (int k = 1; k <= 40; k++) begin
            bus.mode_a_text = k[0];
            cyc(0,1,0,0,0,1,0);
            chk_all($sformatf("txt_w%0d", k), k < 40, 21'(32'h153 + k), 7'(k), k == 40, 2'b00);
        end
        cyc(0,1,0,0,0,0,0); chk_all("txt_after", 0, 21'h17B, 7'd40, 0, 2'b00);

        // Mid-line abort by frame_start
        cyc(0,1,1,0,0,0,0);
        cyc(0,1,0,1,0,0,0); chk_all("abt_go", 1, 21'h17B, 7'd0, 0, 2'b00);
        for (int k = 1; k <= 5; k++) cyc(0,1,0,0,0,1,0);
        chk_all("abt_words", 1, 21'h180, 7'd5, 0, 2'b00);
        bus.vbase = 21'h2000;
        cyc(1,1,0,0,0,0,0); chk_all("abt_frame", 0, 21'h2000, 7'd0, 0, 2'b00);
        cyc(0,0,0,1,0,0,0); chk_all("abt_novpix", 0, 21'h2000, 7'd0, 0, 2'b00);
        cyc(0,1,0,1,0,0,0); chk_all("abt_refetch", 1, 21'h2000, 7'd0, 0, 2'b00);
        cyc(0,1,0,0,1,0,0); chk_all("abt_empty_end", 0, 21'h2000, 7'd0, 1, 2'b01);
        cyc(0,1,0,0,0,0,1); chk_all("abt_clr", 0, 21'h2000, 7'd0, 0, 2'b00);

        // Asynchronous reset in the middle of a fetch
        cyc(0,1,1,0,0,0,0);
        cyc(0,1,0,1,0,0,0);
        cyc(0,1,0,0,0,1,0);
        cyc(0,1,0,0,0,1,0); chk_all("pre_reset", 1, 21'h2002, 7'd2, 0, 2'b00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all("async_reset", 0, 21'h0, 7'd0, 0, 2'b00);
        cyc(0,1,0,1,0,1,0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0,1,0,1,0,0,0); chk_all("post_reset", 0, 21'h0, 7'd0, 0, 2'b00);

        // Address wrap, last word coincident with fetch_end
        bus.mode_atm_n_pent = 1'b0; bus.mode_a_text = 1'b0;
        bus.vbase = 21'h1FFFFE;
        cyc(1,1,0,0,0,0,0); chk_all("wrap_frame", 0, 21'h1FFFFE, 7'd0, 0, 2'b00);
        cyc(0,1,0,1,0,0,0); chk_all("wrap_go", 1, 21'h1FFFFE, 7'd0, 0, 2'b00);
        cyc(0,1,0,0,0,1,0); chk_all("wrap_w1", 1, 21'h1FFFFF, 7'd1, 0, 2'b00);
        cyc(0,1,0,0,0,1,0); chk_all("wrap_w2", 1, 21'h000000, 7'd2, 0, 2'b00);
        cyc(0,1,0,0,0,1,0); chk_all("wrap_w3", 1, 21'h000001, 7'd3, 0, 2'b00);
        cyc(0,1,0,0,1,1,0); chk_all("wrap_w4_end", 0, 21'h000002, 7'd4, 1, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
